// File: rtl/mp_adder_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multi-precision adder between two
// requesters.
// Ports:
//   clk, resetn             clock, async active-low reset
//   reqN_valid/ready        request handshake, N = 0/1
//   reqN_subtract/carry     operation select (A-B when set) and carry-in
//   reqN_a/b                operands, INPUT_WIDTH bits
//   rspN_valid/result       one-cycle result pulse, held result (W+1 bits)
//   add_start/done          adder start pulse and completion pulse
//   add_subtract/carry/a/b  latched operands toward the adder
//   add_result              adder result, W+1 bits
//   busy                    high in any state other than IDLE
//   timeout_err             sticky watchdog flag
module mp_adder_arbiter #(
    parameter int INPUT_WIDTH    = 1027,
    parameter int TIMEOUT_CYCLES = 31
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req0_valid,
    input  logic                   req0_subtract,
    input  logic                   req0_carry,
    input  logic [INPUT_WIDTH-1:0] req0_a,
    input  logic [INPUT_WIDTH-1:0] req0_b,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic                   req1_subtract,
    input  logic                   req1_carry,
    input  logic [INPUT_WIDTH-1:0] req1_a,
    input  logic [INPUT_WIDTH-1:0] req1_b,
    output logic                   req1_ready,
    output logic                   rsp0_valid,
    output logic [INPUT_WIDTH:0]   rsp0_result,
    output logic                   rsp1_valid,
    output logic [INPUT_WIDTH:0]   rsp1_result,
    output logic                   add_start,
    output logic                   add_subtract,
    output logic                   add_carry,
    output logic [INPUT_WIDTH-1:0] add_a,
    output logic [INPUT_WIDTH-1:0] add_b,
    input  logic [INPUT_WIDTH:0]   add_result,
    input  logic                   add_done,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int W  = INPUT_WIDTH;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           owner_q, owner_d;
    logic           sub_q, sub_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W:0]     res0_q, res0_d;
    logic [W:0]     res1_q, res1_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           timeout_q, timeout_d;

    logic           sel0;
    logic           sel1;

    // On a tie the requester that was not served last wins.
    assign sel0 = req0_valid & (~req1_valid | last_grant_q);
    assign sel1 = req1_valid & (~req0_valid | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        sub_d        = sub_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        res0_d       = res0_q;
        res1_d       = res1_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req0_ready = sel0;
                req1_ready = sel1;
                if (sel0 | sel1) begin
                    owner_d = sel1;
                    sub_d   = sel1 ? req1_subtract : req0_subtract;
                    carry_d = sel1 ? req1_carry : req0_carry;
                    a_d     = sel1 ? req1_a : req0_a;
                    b_d     = sel1 ? req1_b : req0_b;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving on the last allowed cycle still wins.
                if (add_done) begin
                    if (owner_q) res1_d = add_result;
                    else         res0_d = add_result;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    if (owner_q) res1_d = '0;
                    else         res0_d = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_grant_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            sub_q        <= 1'b0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            res0_q       <= '0;
            res1_q       <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            sub_q        <= sub_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res0_q       <= res0_d;
            res1_q       <= res1_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign add_start    = (state_q == ST_ISSUE);
    assign add_subtract = sub_q;
    assign add_carry    = carry_q;
    assign add_a        = a_q;
    assign add_b        = b_q;
    assign rsp0_valid   = (state_q == ST_RESP) & ~owner_q;
    assign rsp1_valid   = (state_q == ST_RESP) & owner_q;
    assign rsp0_result  = res0_q;
    assign rsp1_result  = res1_q;
    assign busy         = (state_q != ST_IDLE);
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_mp_adder_arbiter.sv
// Self-checking bench for mp_adder_arbiter with a behavioural fixed-latency
// adder and per-requester result scoreboards.
module tb_mp_adder_arbiter;

    localparam int W   = 1027;
    localparam int TO  = 31;
    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         resetn;
    logic         req0_valid, req0_subtract, req0_carry, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_subtract, req1_carry, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp0_valid, rsp1_valid;
    logic [W:0]   rsp0_result, rsp1_result;
    logic         add_start, add_subtract, add_carry, add_done;
    logic [W-1:0] add_a, add_b;
    logic [W:0]   add_result;
    logic         busy, timeout_err;

    int checks   = 0;
    int failures = 0;

    logic [W:0] sb0[$];
    logic [W:0] sb1[$];

    always #5 clk = ~clk;

    mp_adder_arbiter #(.INPUT_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_subtract(req0_subtract),
        .req0_carry(req0_carry), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_subtract(req1_subtract),
        .req1_carry(req1_carry), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
        .add_start(add_start), .add_subtract(add_subtract),
        .add_carry(add_carry), .add_a(add_a), .add_b(add_b),
        .add_result(add_result), .add_done(add_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [W:0] model_sum(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic sub,
                                             input logic cry);
        logic [W:0] c;
        c = {{W{1'b0}}, cry};
        if (sub) return {1'b0, a} - {1'b0, b} - c;
        return {1'b0, a} + {1'b0, b} + c;
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < (W + 31) / 32; i++)
            v = {v[W-33:0], 32'($urandom)};
        return v;
    endfunction

    // Behavioural adder: done LAT cycles after start, suppressible.
    int         rem;
    logic       model_done;
    logic [W:0] model_res;
    logic       hang = 1'b0;
    logic       spur_done = 1'b0;

    assign add_done   = model_done | spur_done;
    assign add_result = model_res;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem        <= 0;
            model_done <= 1'b0;
            model_res  <= '0;
        end else if (add_start) begin
            rem        <= LAT - 1;
            model_done <= 1'b0;
            model_res  <= model_sum(add_a, add_b, add_subtract, add_carry);
        end else if (rem > 0) begin
            rem        <= rem - 1;
            model_done <= (rem == 1) && !hang;
        end else begin
            model_done <= 1'b0;
        end
    end

    // Scoreboard monitor: every response must match its owner's queue.
    always @(negedge clk) begin
        logic [W:0] e;
        if (resetn) begin
            if (rsp0_valid || rsp1_valid) begin
                checks++;
                if (rsp0_valid && rsp1_valid) begin
                    failures++;
                    $display("FAIL rsp_both_valid got=11 exp=one-hot");
                end
            end
            if (rsp0_valid) begin
                checks++;
                if (sb0.size() == 0) begin
                    failures++;
                    $display("FAIL rsp0_unexpected got=valid exp=none");
                end else begin
                    e = sb0.pop_front();
                    if (rsp0_result !== e) begin
                        failures++;
                        $display("FAIL rsp0_result got_lo=%h exp_lo=%h",
                                 rsp0_result[63:0], e[63:0]);
                    end
                end
            end
            if (rsp1_valid) begin
                checks++;
                if (sb1.size() == 0) begin
                    failures++;
                    $display("FAIL rsp1_unexpected got=valid exp=none");
                end else begin
                    e = sb1.pop_front();
                    if (rsp1_result !== e) begin
                        failures++;
                        $display("FAIL rsp1_result got_lo=%h exp_lo=%h",
                                 rsp1_result[63:0], e[63:0]);
                    end
                end
            end
        end
    end

    task automatic drive(input int n, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sub,
                         input logic cry, input logic v);
        if (n == 0) begin
            req0_valid = v; req0_a = a; req0_b = b;
            req0_subtract = sub; req0_carry = cry;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b;
            req1_subtract = sub; req1_carry = cry;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b0);
        sb0.delete();
        sb1.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, add_start, add_subtract, add_carry, rsp0_valid,
             rsp1_valid, timeout_err, req0_ready, req1_ready} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0",
                     {busy, add_start, add_subtract, add_carry, rsp0_valid,
                      rsp1_valid, timeout_err, req0_ready, req1_ready});
        end
        checks++;
        if (add_a !== '0 || add_b !== '0 || rsp0_result !== '0 ||
            rsp1_result !== '0) begin
            failures++;
            $display("FAIL reset_data got_a=%h got_r0=%h exp=0",
                     add_a[31:0], rsp0_result[31:0]);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_single_add();
        int n;
        int starts;
        @(negedge clk);
        drive(0, W'(5), W'(3), 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL add_ready got=%b%b exp=10", req0_ready, req1_ready);
        end
        sb0.push_back(model_sum(W'(5), W'(3), 1'b0, 1'b0));
        @(negedge clk);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        n = 1;
        starts = 0;
        while (!rsp0_valid && n < 100) begin
            if (add_start) starts++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL add_latency got=%0d exp=12", n);
        end
        checks++;
        if (starts != 1) begin
            failures++;
            $display("FAIL add_start_pulses got=%0d exp=1", starts);
        end
        checks++;
        if (rsp0_result !== (W+1)'(8)) begin
            failures++;
            $display("FAIL add_result got=%h exp=8", rsp0_result[31:0]);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_after got=%b%b exp=00", busy, rsp0_valid);
        end
    endtask

    task automatic test_subtract();
        int k;
        int bad;
        @(negedge clk);
        drive(1, W'(5), W'(3), 1'b1, 1'b0, 1'b1);
        #1;
        k = 0;
        while (!req1_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL sub_ready got=%b exp=1", req1_ready);
        end
        sb1.push_back(model_sum(W'(5), W'(3), 1'b1, 1'b0));
        @(negedge clk);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b0);
        bad = 0;
        k = 0;
        while (k < 100) begin
            if (add_subtract !== 1'b1 || add_a !== W'(5) || add_b !== W'(3))
                bad++;
            if (rsp1_valid) break;
            @(negedge clk);
            k++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sub_operands_stable got=%0d exp=0", bad);
        end
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== (W+1)'(2)) begin
            failures++;
            $display("FAIL sub_result got=%h exp=2", rsp1_result[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic [W-1:0] a0, b0, a1, b1;
        logic         s0, c0, s1, c1;
        int cnt0, cnt1, g, k, pend, bad_both, bad_busy;
        int order[8];
        do_reset();
        a0 = rnd_w(); b0 = rnd_w(); s0 = 1'($urandom); c0 = 1'($urandom);
        a1 = rnd_w(); b1 = rnd_w(); s1 = 1'($urandom); c1 = 1'($urandom);
        drive(0, a0, b0, s0, c0, 1'b1);
        drive(1, a1, b1, s1, c1, 1'b1);
        cnt0 = 0; cnt1 = 0; g = 0; k = 0; pend = -1;
        bad_both = 0; bad_busy = 0;
        while (g < 8 && k < 400) begin
            if (pend == 0) begin
                cnt0++;
                a0 = rnd_w(); b0 = rnd_w();
                s0 = 1'($urandom); c0 = 1'($urandom);
                drive(0, a0, b0, s0, c0, cnt0 < 4);
            end else if (pend == 1) begin
                cnt1++;
                a1 = rnd_w(); b1 = rnd_w();
                s1 = 1'($urandom); c1 = 1'($urandom);
                drive(1, a1, b1, s1, c1, cnt1 < 4);
            end
            pend = -1;
            #1;
            if (req0_ready && req1_ready) bad_both++;
            if (busy && (req0_ready || req1_ready)) bad_busy++;
            if (req0_ready) begin
                order[g] = 0; g++; pend = 0;
                sb0.push_back(model_sum(a0, b0, s0, c0));
            end else if (req1_ready) begin
                order[g] = 1; g++; pend = 1;
                sb1.push_back(model_sum(a1, b1, s1, c1));
            end
            @(negedge clk);
            k++;
        end
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (g != 8) begin
            failures++;
            $display("FAIL tie_grants got=%0d exp=8", g);
        end
        for (int i = 0; i < g; i++) begin
            checks++;
            if (order[i] != (i % 2)) begin
                failures++;
                $display("FAIL tie_order[%0d] got=%0d exp=%0d",
                         i, order[i], i % 2);
            end
        end
        checks++;
        if (bad_both != 0 || bad_busy != 0) begin
            failures++;
            $display("FAIL tie_ready both=%0d busy=%0d exp=0 0",
                     bad_both, bad_busy);
        end
        k = 0;
        while ((busy || sb0.size() != 0 || sb1.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0 || busy) begin
            failures++;
            $display("FAIL tie_drain got=%0d/%0d exp=0/0",
                     sb0.size(), sb1.size());
        end
    endtask

    task automatic test_watchdog();
        int n, k, early;
        logic [W-1:0] a, b;
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL wd_pre got=%b exp=0", timeout_err);
        end
        hang = 1'b1;
        drive(0, rnd_w(), rnd_w(), 1'b0, 1'b1, 1'b1);
        #1;
        k = 0;
        while (!req0_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        sb0.push_back('0);
        @(negedge clk);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        n = 1;
        early = 0;
        while (!rsp0_valid && n < 100) begin
            if (timeout_err) early++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 33) begin
            failures++;
            $display("FAIL wd_latency got=%0d exp=33", n);
        end
        checks++;
        if (timeout_err !== 1'b1 || early != 0) begin
            failures++;
            $display("FAIL wd_flag got=%b early=%0d exp=1 0",
                     timeout_err, early);
        end
        checks++;
        if (rsp0_result !== '0) begin
            failures++;
            $display("FAIL wd_result got=%h exp=0", rsp0_result[63:0]);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wd_idle got=%b exp=0", busy);
        end
        hang = 1'b0;
        a = rnd_w();
        b = rnd_w();
        drive(1, a, b, 1'b1, 1'b1, 1'b1);
        #1;
        k = 0;
        while (!req1_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        sb1.push_back(model_sum(a, b, 1'b1, 1'b1));
        @(negedge clk);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (!rsp1_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (rsp1_valid !== 1'b1 || k != 11) begin
            failures++;
            $display("FAIL wd_recover got=%b lat=%0d exp=1 11", rsp1_valid, k);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL wd_sticky got=%b exp=1", timeout_err);
        end
        @(negedge clk);
    endtask

    task automatic test_spurious();
        logic [W:0] r0, r1;
        int bad;
        @(negedge clk);
        r0 = rsp0_result;
        r1 = rsp1_result;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy || rsp0_valid || rsp1_valid) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL spurious_done got=%0d exp=0", bad);
        end
        checks++;
        if (rsp0_result !== r0 || rsp1_result !== r1) begin
            failures++;
            $display("FAIL spurious_result got_lo=%h exp_lo=%h",
                     rsp0_result[63:0], r0[63:0]);
        end
    endtask

    task automatic test_reset_mid_wait();
        int k, bad;
        logic [W-1:0] a, b;
        @(negedge clk);
        drive(0, rnd_w(), rnd_w(), 1'b0, 1'b0, 1'b1);
        #1;
        k = 0;
        while (!req0_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(negedge clk);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_busy got=%b exp=1", busy);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({busy, add_start, add_subtract, add_carry, rsp0_valid,
             rsp1_valid, timeout_err} !== 7'b0) begin
            failures++;
            $display("FAIL rst_mid_ctrl got=%b exp=0",
                     {busy, add_start, add_subtract, add_carry, rsp0_valid,
                      rsp1_valid, timeout_err});
        end
        checks++;
        if (add_a !== '0 || add_b !== '0 || rsp0_result !== '0 ||
            rsp1_result !== '0) begin
            failures++;
            $display("FAIL rst_mid_data got_r0=%h got_r1=%h exp=0",
                     rsp0_result[63:0], rsp1_result[63:0]);
        end
        sb0.delete();
        sb1.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || rsp0_valid || rsp1_valid) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_no_rsp got=%0d exp=0", bad);
        end
        a = rnd_w();
        b = rnd_w();
        drive(0, a, b, 1'b0, 1'b0, 1'b1);
        drive(1, rnd_w(), rnd_w(), 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_first_grant got=%b%b exp=10",
                     req0_ready, req1_ready);
        end
        sb0.push_back(model_sum(a, b, 1'b0, 1'b0));
        @(negedge clk);
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b0);
        k = 0;
        while ((busy || sb0.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (sb0.size() != 0 || busy) begin
            failures++;
            $display("FAIL rst_next_op got=%0d exp=0", sb0.size());
        end
    endtask

    initial begin
        resetn = 1'b0;
        drive(0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1, '0, '0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single_add();
        test_subtract();
        test_tie();
        test_watchdog();
        test_spurious();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
